// File: rtl/spi_stash_if.sv
// Bus between the host-side stash sequencer and its environment (host + SPI master).
// Signalling contract: START, ABORT, HOST_WR, DONE and LEN_ERR are single-cycle
// strobes sampled on the rising clock edge with no ready back-pressure. BUSY is the only
// status level, and an accepted START is visible as BUSY=1 after the next edge.
// STASH_PTR/MISO_DATA are qualified by a change of STASH_PTR, not by a valid strobe.
interface spi_stash_if #(
    parameter int ADDR_W = 4
);
    logic              host_wr;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic [7:0]        host_rdata;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              len_err;
    logic              enable;
    logic [7:0]        mosi_data;
    logic [7:0]        miso_data;
    logic [7:0]        stash_ptr;
    logic [7:0]        rx_crc;

    // The sequencer side
    modport slave (
        input  host_wr, host_addr, host_wdata, start, len, abort, miso_data, stash_ptr,
        output host_rdata, busy, done, len_err, enable, mosi_data, rx_crc
    );

    // The host / SPI master side
    modport master (
        output host_wr, host_addr, host_wdata, start, len, abort, miso_data, stash_ptr,
        input  host_rdata, busy, done, len_err, enable, mosi_data, rx_crc
    );
endinterface

// File: rtl/spi_stash_sequencer.sv
// Byte stash and transaction sequencer feeding a mode-0 SPI master.
// Optional feature macro: SPI_STASH_RX_CRC_EN adds a CRC-8 (poly 0x07) over RX bytes.
// state_o exposes the FSM state (0=IDLE, 1=RUN, 2=FINISH) for debug.
module spi_stash_sequencer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic         ctrl_clk_i,
    input  logic         rst_i,
    spi_stash_if.slave   bus,
    output logic [1:0]   state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];

    state_t          state_q, state_d;
    logic [ADDR_W:0] idx_q, idx_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [7:0]      ptr_q, ptr_d;
    logic [7:0]      mosi_q, mosi_d;
    logic            enable_q, enable_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            len_err_q, len_err_d;
    logic [7:0]      rdata_q;

    logic            len_ok;
    logic            accept;
    logic            capture;
    logic            last;
    logic [ADDR_W:0] idx_nxt;

    assign len_ok  = (bus.len != '0) && (bus.len <= DEPTH_L);
    assign accept  = (state_q == S_IDLE) && bus.start && !bus.abort && len_ok;
    // Any difference from the last seen pointer is one transfer, however far it moved.
    assign capture = (state_q == S_RUN) && (bus.stash_ptr != ptr_q);
    assign last    = (idx_q == len_q - ONE);
    assign idx_nxt = idx_q + ONE;

    // Next-state and output decode for the transfer sequencer
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        ptr_d     = ptr_q;
        mosi_d    = mosi_q;
        enable_d  = enable_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (len_ok) begin
                        ptr_d    = bus.stash_ptr;
                        idx_d    = '0;
                        len_d    = bus.len;
                        mosi_d   = tx_mem[0];
                        enable_d = 1'b0;
                        busy_d   = 1'b1;
                        state_d  = S_RUN;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (capture) begin
                    ptr_d = bus.stash_ptr;
                    idx_d = idx_nxt;
                    if (last) begin
                        // Release the master on the same edge; MOSI holds its last byte.
                        enable_d = 1'b1;
                        state_d  = S_FINISH;
                    end else begin
                        mosi_d = tx_mem[idx_nxt[ADDR_W-1:0]];
                    end
                end
                // Abort overrides the state change but not the capture write.
                if (bus.abort) begin
                    enable_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                done_d  = !bus.abort;
            end
            default: begin
                enable_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge ctrl_clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            ptr_q     <= '0;
            mosi_q    <= '0;
            enable_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            ptr_q     <= ptr_d;
            mosi_q    <= mosi_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    // Stash RAMs: TX frozen while busy, RX written on each capture; contents not reset
    always_ff @(posedge ctrl_clk_i) begin
        if (!rst_i && bus.host_wr && !busy_q) begin
            tx_mem[bus.host_addr] <= bus.host_wdata;
        end
        if (!rst_i && capture) begin
            rx_mem[idx_q[ADDR_W-1:0]] <= bus.miso_data;
        end
    end

    // Registered host read port
    always_ff @(posedge ctrl_clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rx_mem[bus.host_addr];
        end
    end

`ifdef SPI_STASH_RX_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // CRC is cleared by an accepted START and folds in every captured byte
    always_comb begin
        crc_d = crc_q;
        if (accept) begin
            crc_d = 8'h00;
        end else if (capture) begin
            crc_d = crc8_update(crc_q, bus.miso_data);
        end
    end

    // CRC register
    always_ff @(posedge ctrl_clk_i) begin
        if (rst_i) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign bus.rx_crc = crc_q;
`else
    assign bus.rx_crc = 8'h00;
`endif

    assign bus.host_rdata = rdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.len_err    = len_err_q;
    assign bus.enable     = enable_q;
    assign bus.mosi_data  = mosi_q;
    assign state_o        = state_q;
endmodule
